i2s_rx_deser: RTL

Serial-to-parallel I2S receiver in the slow bit-clock domain, directly upstream of the slow-to-fast CDC FIFO. It deserialises the ADC/codec I2S stream (BCLK 1.4112 MHz, 32 BCLK per 44.1 kHz frame, 16 bits per channel slot, MSB first). It emits one selected channel as a 16-bit packet with a single-cycle valid strobe. These outputs feed the CDC write port (packet + write-enable) unchanged.

---
 rtl/i2s_pkg.sv | 24 ++
 rtl/i2s_rx_deser_if.sv | 25 ++
 rtl/i2s_rx_deser.sv | 101 ++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: frame geometry, channel selectors and receiver state encoding.
// Reused by the RX deserialiser, the CDC FIFO and the TX serialiser.
package i2s_pkg;

  localparam int PKT_WIDTH = 16;
  localparam int SLOT_BITS = 16;

  localparam int CHAN_LEFT  = 0;
  localparam int CHAN_RIGHT = 1;
  localparam int CHAN_BOTH  = 2;

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    RECEIVE   = 1'b1
  } i2sRxState_t;

  // Channel 0 is left (WS low), channel 1 is right (WS high).
  function automatic logic chanSelected(input int chanSel, input logic chan);
    return (chanSel == CHAN_BOTH) ||
           ((chanSel == CHAN_LEFT) && !chan) ||
           ((chanSel == CHAN_RIGHT) && chan);
  endfunction

endpackage

// File: rtl/i2s_rx_deser_if.sv
// Serial input and parallel packet bundle of the I2S receiver.
// master = stream source / packet consumer side, slave = the deserialiser.
interface i2s_rx_deser_if #(
  parameter int PKT_WIDTH = i2s_pkg::PKT_WIDTH
) ();

  logic                 i2sWS_i;
  logic                 i2sSD_i;
  logic                 errClr_i;
  logic [PKT_WIDTH-1:0] pktI2S_o;
  logic                 pktValidI2S_o;
  logic                 pktChan_o;
  logic                 syncErr_o;

  modport master (
    output i2sWS_i, i2sSD_i, errClr_i,
    input  pktI2S_o, pktValidI2S_o, pktChan_o, syncErr_o
  );

  modport slave (
    input  i2sWS_i, i2sSD_i, errClr_i,
    output pktI2S_o, pktValidI2S_o, pktChan_o, syncErr_o
  );

endinterface

// File: rtl/i2s_rx_deser.sv
// I2S serial-to-parallel receiver in the BCLK domain; emits one selected channel
// (or both) as a packet with a one-cycle valid strobe for the CDC write port.
module i2s_rx_deser
  import i2s_pkg::*;
#(
  parameter int PKT_WIDTH = i2s_pkg::PKT_WIDTH,  // must equal SLOT_BITS
  parameter int SLOT_BITS = i2s_pkg::SLOT_BITS,
  parameter int CHAN_SEL  = i2s_pkg::CHAN_LEFT
) (
  input  logic           clkI2SBit_i,
  input  logic           rstI2S_n_i,
  i2s_rx_deser_if.slave  i2sBus
);

  localparam int                CNT_W    = $clog2(2 * SLOT_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(2 * SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_BITS - 1);

  i2sRxState_t          state;
  i2sRxState_t          stateNext;
  logic                 wsPrev;
  logic [CNT_W-1:0]     bitCnt;
  logic [PKT_WIDTH-2:0] shiftReg;  // the LSB arrives live on the edge cycle
  logic                 wsEdge;
  logic                 slotGood;
  logic                 emitPkt;
  logic                 setErr;
  logic [PKT_WIDTH-1:0] word;

  assign wsEdge = (i2sBus.i2sWS_i != wsPrev);
  assign word   = {shiftReg, i2sBus.i2sSD_i};

  always_ff @(posedge clkI2SBit_i or negedge rstI2S_n_i) begin
    if (!rstI2S_n_i) begin
      state <= SYNC_WAIT;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    stateNext = state;
    slotGood  = 1'b0;
    emitPkt   = 1'b0;
    setErr    = 1'b0;
    unique case (state)
      SYNC_WAIT: begin
        // The slot closed by the first edge started before we were listening.
        if (wsEdge) stateNext = RECEIVE;
      end
      RECEIVE: begin
        if (wsEdge) begin
          slotGood = (bitCnt == CNT_LAST);
          emitPkt  = slotGood && chanSelected(CHAN_SEL, wsPrev);
          setErr   = !slotGood;
        end
      end
    endcase
  end

  always_ff @(posedge clkI2SBit_i or negedge rstI2S_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rstI2S_n_i) begin
      wsPrev   <= 1'b0;
      bitCnt   <= '0;
      // NOTE: the shift register is reset too; it is a handful of flops, not a memory array.
      shiftReg <= '0;
    end else begin
      wsPrev   <= i2sBus.i2sWS_i;
      shiftReg <= word[PKT_WIDTH-2:0];
      if (wsEdge) begin
        bitCnt <= '0;
      end else if (bitCnt != CNT_MAX) begin
        bitCnt <= bitCnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clkI2SBit_i or negedge rstI2S_n_i) begin
    if (!rstI2S_n_i) begin
      i2sBus.pktI2S_o      <= '0;
      i2sBus.pktValidI2S_o <= 1'b0;
      i2sBus.pktChan_o     <= 1'b0;
      i2sBus.syncErr_o     <= 1'b0;
    end else begin
      i2sBus.pktValidI2S_o <= emitPkt;
      if (emitPkt) begin
        i2sBus.pktI2S_o  <= word;
        i2sBus.pktChan_o <= wsPrev;
      end
      // A new error takes precedence over a coincident clear.
      if (setErr) begin
        i2sBus.syncErr_o <= 1'b1;
      end else if (i2sBus.errClr_i) begin
        i2sBus.syncErr_o <= 1'b0;
      end
    end
  end

endmodule
